morse_digit_player: RTL and testbench
=====================================

MORSE_DIGIT_PLAYER -- requirements
Module: morse_digit_player

Interface
REQ-001 SHALL have parameter UNIT_CYCLES, default 12500000, meaning clock cycles per Morse time unit (0.25 s at 50 MHz); legal range 1 to 2^24-1.
REQ-002 SHALL have port clk  input  1  single system clock; all state updates on its rising edge.
REQ-003 SHALL have port rst  input  1  asynchronous, active-high reset.
REQ-004 SHALL have port start  input  1  request to play the digit currently presented on digit.
REQ-005 SHALL have port digit  input  4  decimal digit to play, 0-9; sourced from the random-digit generator output.
REQ-006 SHALL have port ready  output  1  high when idle and able to accept start.
REQ-007 SHALL have port led  output  1  Morse key output; 1 = mark (tone/LED on).
REQ-008 SHALL have port done  output  1  one-cycle pulse when playback completes.
REQ-009 SHALL have port err  output  1  one-cycle pulse when start is issued with digit > 9.

Function
REQ-010 SHALL use FSM states IDLE, MARK, GAP and TAIL; ready = (state == IDLE).
REQ-011 SHALL accept a request when start=1, ready=1 and digit<=9 on a rising clk edge: latch digit, clear symbol index to 0 and enter MARK.
REQ-012 SHALL ignore start while ready=0; the latched digit SHALL NOT change during playback.
REQ-013 SHALL, when start=1, ready=1 and digit>9, stay in IDLE and pulse err for exactly one cycle, with no led activity.
REQ-014 SHALL encode each digit as 5 symbols, index 0 first: d in 1..5 gives d dots then dashes; d in 6..9 gives (d-5) dashes then dots; 0 gives five dashes.
REQ-015 SHALL drive led=1 only in MARK: a dot lasts 1 unit and a dash lasts 3 units (1 unit = UNIT_CYCLES cycles).
REQ-016 SHALL follow MARK with GAP (led=0, 1 unit) for symbol indices 0-3, then increment the index and return to MARK; after index 4, MARK SHALL go to TAIL.
REQ-017 SHALL hold TAIL (led=0) for 3 units, then enter IDLE.
REQ-018 SHALL assert done for one cycle, in the first IDLE cycle after TAIL, coincident with ready=1; a start in that cycle SHALL be accepted.
REQ-019 SHALL drive led=1 from the first cycle after acceptance; total busy time = (marks + 4 + 3) units, e.g. digit 5 = 12 units and digit 0 = 22 units.
REQ-020 SHALL use a down-counter of at least 26 bits for the unit timer (3*UNIT_CYCLES max) that reloads on every state entry, with no wrap-around.
REQ-021 SHALL register all outputs; no output is combinational from inputs.

Reset
REQ-022 SHALL on rst=1, at any time including mid-playback, immediately force state=IDLE, led=0, done=0, err=0, ready=1, counters=0 and latched digit=0.
REQ-023 SHALL NOT produce a done pulse for a playback aborted by reset; operation resumes on the first clk edge after rst deasserts.

Configuration
REQ-024 SHALL, when macro MORSE_PLAYER_REPEAT_EN is defined, play the latched digit twice: after the first TAIL the block re-enters MARK at index 0 instead of IDLE, and done pulses only after the second TAIL.
REQ-025 SHALL, without MORSE_PLAYER_REPEAT_EN, play the digit once, and the repeat logic SHALL be absent.

Verification (UNIT_CYCLES=2, macro undefined unless stated)
REQ-026 Digit 5 accepted at edge k -> led = five 2-cycle highs separated by 2-cycle lows starting cycle k+1; done at cycle k+25; ready low k+1..k+24.
REQ-027 Digit 0 -> five 6-cycle highs with 2-cycle lows; done 44 cycles after acceptance.
REQ-028 Start with digit=12 -> err=1 for one cycle, ready stays 1, led stays 0, no done.
REQ-029 Digit 7 playing, start pulsed with digit 3 mid-playback -> ignored; pattern stays --... (6,6,2,2,2 cycles high).
REQ-030 rst pulsed during the second mark of digit 1 -> led=0 and ready=1 asynchronously; no done; a later start with digit 2 plays ..--- normally.
REQ-031 With MORSE_PLAYER_REPEAT_EN, digit 1 -> .---- played twice, 6-cycle tail between; single done after 80 cycles.

Source files
------------

// File: rtl/morse_digit_player.sv
// morse_digit_player: plays one decimal digit (0-9) as its 5-symbol Morse code on led.
// Timing is in units of UNIT_CYCLES clock cycles: dot = 1 unit, dash = 3 units,
// intra-digit gap = 1 unit, trailing gap = 3 units.
// Optional feature macro: MORSE_PLAYER_REPEAT_EN plays the latched digit twice
// before signalling done.
module morse_digit_player #(
    parameter int unsigned UNIT_CYCLES = 12500000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic [3:0] digit,
    output logic       ready,
    output logic       led,
    output logic       done,
    output logic       err
);

    typedef enum logic [1:0] {IDLE, MARK, GAP, TAIL} state_t;

    // Reload values: the counter runs from N-1 down to 0, giving N cycles per state visit.
    localparam logic [25:0] CNT_ONE   = 26'(UNIT_CYCLES - 1);
    localparam logic [25:0] CNT_THREE = 26'(3 * UNIT_CYCLES - 1);

    state_t      state_q, state_d;
    logic [25:0] cnt_q, cnt_d;
    logic [2:0]  idx_q, idx_d;
    logic [3:0]  dig_q, dig_d;
    logic        err_d, done_d;
`ifdef MORSE_PLAYER_REPEAT_EN
    logic        pass_q, pass_d;
`endif

    // Symbol at position i of digit d: 1 = dash, 0 = dot.
    function automatic logic is_dash(input logic [3:0] d, input logic [2:0] i);
        logic [3:0] ii;
        ii = {1'b0, i};
        if (d == 4'd0) begin
            return 1'b1;
        end else if (d <= 4'd5) begin
            return (ii >= d);
        end else begin
            return (ii < (d - 4'd5));
        end
    endfunction

    function automatic logic [25:0] mark_len(input logic [3:0] d, input logic [2:0] i);
        return is_dash(d, i) ? CNT_THREE : CNT_ONE;
    endfunction

    // Next-state logic: the unit counter is reloaded on every state entry.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        dig_d   = dig_q;
        err_d   = 1'b0;
        done_d  = 1'b0;
`ifdef MORSE_PLAYER_REPEAT_EN
        pass_d  = pass_q;
`endif
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    if (digit <= 4'd9) begin
                        dig_d   = digit;
                        idx_d   = 3'd0;
                        state_d = MARK;
                        cnt_d   = mark_len(digit, 3'd0);
`ifdef MORSE_PLAYER_REPEAT_EN
                        pass_d  = 1'b0;
`endif
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            MARK: begin
                if (cnt_q == 26'd0) begin
                    if (idx_q == 3'd4) begin
                        state_d = TAIL;
                        cnt_d   = CNT_THREE;
                    end else begin
                        state_d = GAP;
                        cnt_d   = CNT_ONE;
                    end
                end else begin
                    cnt_d = cnt_q - 26'd1;
                end
            end
            GAP: begin
                if (cnt_q == 26'd0) begin
                    idx_d   = idx_q + 3'd1;
                    state_d = MARK;
                    cnt_d   = mark_len(dig_q, idx_q + 3'd1);
                end else begin
                    cnt_d = cnt_q - 26'd1;
                end
            end
            TAIL: begin
                if (cnt_q == 26'd0) begin
`ifdef MORSE_PLAYER_REPEAT_EN
                    if (!pass_q) begin
                        // Second pass of the same latched digit.
                        pass_d  = 1'b1;
                        idx_d   = 3'd0;
                        state_d = MARK;
                        cnt_d   = mark_len(dig_q, 3'd0);
                    end else begin
                        pass_d  = 1'b0;
                        state_d = IDLE;
                        cnt_d   = 26'd0;
                        done_d  = 1'b1;
                    end
`else
                    state_d = IDLE;
                    cnt_d   = 26'd0;
                    done_d  = 1'b1;
`endif
                end else begin
                    cnt_d = cnt_q - 26'd1;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = 26'd0;
            end
        endcase
    end

    // State and datapath registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= 26'd0;
            idx_q   <= 3'd0;
            dig_q   <= 4'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            dig_q   <= dig_d;
        end
    end

`ifdef MORSE_PLAYER_REPEAT_EN
    // Tracks which of the two passes is playing.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pass_q <= 1'b0;
        end else begin
            pass_q <= pass_d;
        end
    end
`endif

    // Outputs registered from next state so they line up exactly with state_q.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ready <= 1'b1;
            led   <= 1'b0;
            done  <= 1'b0;
            err   <= 1'b0;
        end else begin
            ready <= (state_d == IDLE);
            led   <= (state_d == MARK);
            done  <= done_d;
            err   <= err_d;
        end
    end

endmodule

// File: tb/tb_morse_digit_player.sv
// Directed bench for morse_digit_player with UNIT_CYCLES = 2.
// Define MORSE_PLAYER_REPEAT_EN for both bench and RTL to check the repeat build.
module tb_morse_digit_player;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic [3:0] digit;
    logic       ready;
    logic       led;
    logic       done;
    logic       err;

    int checks = 0;
    int errors = 0;

    morse_digit_player #(
        .UNIT_CYCLES(2)
    ) dut (
        .clk  (clk),
        .rst  (rst),
        .start(start),
        .digit(digit),
        .ready(ready),
        .led  (led),
        .done (done),
        .err  (err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %b expected %b at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic chk_out(input string tag, input logic e_led, input logic e_ready,
                           input logic e_done, input logic e_err);
        chk({tag, ".led"}, led, e_led);
        chk({tag, ".ready"}, ready, e_ready);
        chk({tag, ".done"}, done, e_done);
        chk({tag, ".err"}, err, e_err);
    endtask

    // Drive a start request in the current cycle; returns in the cycle after the edge.
    task automatic accept(input logic [3:0] d);
        digit = d;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    // One busy cycle: check, optionally inject an ignored start, advance.
    task automatic busy_cycle(input string tag, input logic e_led, input int ign_at,
                              input logic [3:0] ign_digit, inout int cyc);
        chk_out(tag, e_led, 1'b0, 1'b0, 1'b0);
        if (cyc == ign_at) begin
            digit = ign_digit;
            start = 1'b1;
        end else begin
            start = 1'b0;
        end
        @(negedge clk);
        start = 1'b0;
        cyc++;
    endtask

    // Expects the full playback given hand-computed mark lengths (cycles); ends in done cycle.
    task automatic play(input string tag, input int m0, input int m1, input int m2,
                        input int m3, input int m4, input int ign_at,
                        input logic [3:0] ign_digit);
        int m[5];
        int cyc;
        int reps;
        m    = '{m0, m1, m2, m3, m4};
        cyc  = 1;
`ifdef MORSE_PLAYER_REPEAT_EN
        reps = 2;
`else
        reps = 1;
`endif
        for (int r = 0; r < reps; r++) begin
            for (int s = 0; s < 5; s++) begin
                for (int i = 0; i < m[s]; i++) busy_cycle(tag, 1'b1, ign_at, ign_digit, cyc);
                if (s < 4) begin
                    for (int i = 0; i < 2; i++) busy_cycle(tag, 1'b0, ign_at, ign_digit, cyc);
                end else begin
                    for (int i = 0; i < 6; i++) busy_cycle(tag, 1'b0, ign_at, ign_digit, cyc);
                end
            end
        end
        chk_out({tag, ".done_cycle"}, 1'b0, 1'b1, 1'b1, 1'b0);
    endtask

    initial begin
        logic [5:0] pre_rst_pat;
        pre_rst_pat = 6'b110011;  // cycles 6..1 of digit 1: mark, gap, start of dash

        rst   = 1'b1;
        start = 1'b0;
        digit = 4'd0;
        #1;
        chk_out("reset", 1'b0, 1'b1, 1'b0, 1'b0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk_out("idle", 1'b0, 1'b1, 1'b0, 1'b0);

        // Digit 5: five dots.
        accept(4'd5);
        play("d5", 2, 2, 2, 2, 2, 0, 4'd0);
        @(negedge clk);
        chk_out("d5.after", 1'b0, 1'b1, 1'b0, 1'b0);

        // Out-of-range digit.
        accept(4'd12);
        chk_out("d12.err", 1'b0, 1'b1, 1'b0, 1'b1);
        @(negedge clk);
        chk_out("d12.after", 1'b0, 1'b1, 1'b0, 1'b0);

        // Digit 7 with a start for digit 3 during the second dash (ignored).
        accept(4'd7);
        play("d7", 6, 6, 2, 2, 2, 9, 4'd3);

        // Start in the done cycle is accepted: digit 0, five dashes.
        accept(4'd0);
        play("d0", 6, 6, 6, 6, 6, 0, 4'd0);
        @(negedge clk);
        chk_out("d0.after", 1'b0, 1'b1, 1'b0, 1'b0);

        // Digit 1 aborted by reset during its second mark.
        accept(4'd1);
        for (int i = 0; i < 6; i++) begin
            chk_out("d1.pre_rst", pre_rst_pat[i], 1'b0, 1'b0, 1'b0);
            @(negedge clk);
        end
        rst = 1'b1;
        #1;
        chk_out("d1.async_rst", 1'b0, 1'b1, 1'b0, 1'b0);
        #2;
        rst = 1'b0;
        @(negedge clk);
        for (int i = 0; i < 30; i++) begin
            chk_out("d1.post_rst", 1'b0, 1'b1, 1'b0, 1'b0);
            @(negedge clk);
        end

        // Digit 2 plays normally after the abort.
        accept(4'd2);
        play("d2", 2, 2, 6, 6, 6, 0, 4'd0);
        @(negedge clk);
        chk_out("d2.after", 1'b0, 1'b1, 1'b0, 1'b0);

`ifdef MORSE_PLAYER_REPEAT_EN
        // Digit 1 twice: 80 busy cycles, single done.
        accept(4'd1);
        play("d1.rep", 2, 6, 6, 6, 6, 0, 4'd0);
        @(negedge clk);
        chk_out("d1.rep.after", 1'b0, 1'b1, 1'b0, 1'b0);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
